aurora_qpll1_reset_sequencer: RTL



---
 rtl/aurora_qpll1_reset_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/aurora_qpll1_reset_sequencer.sv
// QPLL1 reset sequencer for the Aurora 64b66b quad: timed reset, lock wait with
// timeout, lock-stability qualification, bounded retries and loss supervision.
module aurora_qpll1_reset_sequencer #(
  parameter int RESET_HOLD_CYCLES   = 128,
  parameter int LOCK_TIMEOUT_CYCLES = 262144,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       init_clk,
  input  logic       rst_n,
  input  logic       force_reset,
  input  logic       qpll1_lock,
  input  logic       qpll1_refclklost,
  output logic       qpll1_reset,
  output logic       pll_ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_W = max2(18, max2($clog2(RESET_HOLD_CYCLES),
                                  max2($clog2(LOCK_TIMEOUT_CYCLES),
                                       $clog2(LOCK_STABLE_CYCLES))));

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_ASSERT_RST = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_READY      = 3'd3,
    ST_FAIL       = 3'd4
  } state_e;

  logic             lock_meta, lock_s;
  logic             lost_meta, lost_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic             counting;

  // NOTE: synchronizer flops reset to 0 so a stale lock cannot skip the reset hold.
  always_ff @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      lost_meta <= 1'b0;
      lost_s    <= 1'b0;
    end else begin
      lock_meta <= qpll1_lock;
      lock_s    <= lock_meta;
      lost_meta <= qpll1_refclklost;
      lost_s    <= lost_meta;
    end
  end

  // Failed attempts saturate so the count can never wrap back below the limit.
  assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 4'd1;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_ASSERT_RST: begin
        if (!lost_s && cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lost_s) begin
          state_d = ST_ASSERT_RST;
        end else if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_ASSERT_RST;
        end
      end
      ST_STABLE: begin
        if (lost_s) begin
          state_d = ST_ASSERT_RST;
        end else if (!lock_s) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_ASSERT_RST;
        end else if (cnt_q == STABLE_LAST) begin
          retry_d = 4'd0;
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (!lock_s || lost_s) state_d = ST_ASSERT_RST;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_ASSERT_RST;
      end
    endcase
    if (force_reset) begin
      state_d = ST_ASSERT_RST;
      retry_d = 4'd0;
    end
  end

  assign counting = (state_q == ST_ASSERT_RST) || (state_q == ST_WAIT_LOCK) ||
                    (state_q == ST_STABLE);

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge init_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ASSERT_RST;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      qpll1_reset <= 1'b1;
      pll_ready   <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      if (force_reset || state_d != state_q || (state_q == ST_ASSERT_RST && lost_s)) begin
        cnt_q <= '0;
      end else if (counting) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      qpll1_reset <= (state_d == ST_ASSERT_RST) || (state_d == ST_FAIL);
      pll_ready   <= (state_d == ST_READY);
      fail        <= (state_d == ST_FAIL);
    end
  end

  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
